// File: rtl/rr_packet_mux_arbiter.sv
// rtl/rr_packet_mux_arbiter.sv - packet-aware round-robin 4:1 arbiter with registered output channel
module rr_packet_mux_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    input  logic [3:0]       in_last,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [1:0]       out_src,
    input  logic             out_ready
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [1:0]       out_src_q, out_src_d;

    logic             load;
    logic [1:0]       scan_idx;
    logic [1:0]       cand_idx;
    logic             cand_found;
    logic [1:0]       sel;
    logic             eligible;
    logic             xfer;
    logic [WIDTH-1:0] mux_data;

    assign load = !out_valid_q || out_ready;

    // Scan starts one past the last packet-ending grant, so that requester gets lowest priority.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = ptr_q;
        scan_idx   = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = ptr_q + k[1:0];
            if (!cand_found && in_valid[scan_idx]) begin
                cand_found = 1'b1;
                cand_idx   = scan_idx;
            end
        end
    end

    assign sel      = (state_q == ST_BUSY) ? owner_q : cand_idx;
    assign eligible = in_valid[sel];
    assign in_ready = (load && eligible) ? (4'b0001 << sel) : 4'b0000;
    assign xfer     = load && eligible;

    always_comb begin
        case (sel)
            2'd0:    mux_data = d0;
            2'd1:    mux_data = d1;
            2'd2:    mux_data = d2;
            default: mux_data = d3;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = mux_data;
                out_last_d = in_last[sel];
                out_src_d  = sel;
                if (in_last[sel]) begin
                    state_d = ST_IDLE;
                    ptr_d   = sel;
                end else begin
                    state_d = ST_BUSY;
                    owner_d = sel;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= 2'd0;
            ptr_q       <= 2'd3;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule
